// File: rtl/wb_slave_fabric.sv
// Wishbone-classic address decoder and router from one master to NUM_SLAVES slaves,
// with a per-request timeout and a sticky fault-status capture.
module wb_slave_fabric #(
    parameter int                        NUM_SLAVES   = 4,
    parameter int                        AW           = 32,
    parameter int                        DW           = 32,
    parameter logic [NUM_SLAVES*AW-1:0]  SLAVE_BASE   = {32'h0360_0000, 32'h0350_0000,
                                                         32'h0340_0000, 32'h0330_0000},
    parameter logic [NUM_SLAVES*AW-1:0]  SLAVE_MASK   = {4{32'hFFFF_0000}},
    parameter int                        TIMEOUT      = 255,
    parameter logic [DW-1:0]             DEFAULT_DATA = 32'hBADA_CCE5,
    parameter bit                        ERR_MODE     = 1'b0
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic [AW-1:0]            m_adr,
    input  logic [DW-1:0]            m_dat_w,
    input  logic [DW/8-1:0]          m_sel,
    input  logic                     m_we,
    input  logic                     m_cyc,
    input  logic                     m_stb,
    output logic [DW-1:0]            m_dat_r,
    output logic                     m_ack,
    output logic                     m_err,
    output logic [AW-1:0]            s_adr,
    output logic [DW-1:0]            s_dat_w,
    output logic [DW/8-1:0]          s_sel,
    output logic                     s_we,
    output logic [NUM_SLAVES-1:0]    s_stb,
    input  logic [NUM_SLAVES*DW-1:0] s_dat_r,
    input  logic [NUM_SLAVES-1:0]    s_ack,
    input  logic                     flt_clr,
    output logic                     flt_valid,
    output logic [AW-1:0]            flt_adr,
    output logic                     flt_tmo,
    output logic [1:0]               dbg_state
);
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_w_q, dat_w_d;
    logic [DW/8-1:0] bsel_q, bsel_d;
    logic            we_q, we_d;
    logic [DW-1:0]   dat_r_q, dat_r_d;
    logic            fault_q, fault_d;
    logic            flt_valid_q, flt_valid_d;
    logic [AW-1:0]   flt_adr_q, flt_adr_d;
    logic            flt_tmo_q, flt_tmo_d;

    logic            hit;
    logic [SW-1:0]   hit_idx;
    logic            fault_evt;
    logic            fault_tmo;
    logic [AW-1:0]   fault_adr;

    // Scan from the top index down so the lowest matching window is the last to win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((m_adr & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW]) begin
                hit     = 1'b1;
                hit_idx = SW'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        dat_w_d   = dat_w_q;
        bsel_d    = bsel_q;
        we_d      = we_q;
        dat_r_d   = dat_r_q;
        fault_d   = fault_q;
        fault_evt = 1'b0;
        fault_tmo = 1'b0;
        fault_adr = adr_q;
        case (state_q)
            ST_IDLE: begin
                if (m_cyc && m_stb) begin
                    adr_d   = m_adr;
                    dat_w_d = m_dat_w;
                    bsel_d  = m_sel;
                    we_d    = m_we;
                    cnt_d   = '0;
                    if (hit) begin
                        sel_d   = hit_idx;
                        fault_d = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        fault_d   = 1'b1;
                        dat_r_d   = DEFAULT_DATA;
                        fault_evt = 1'b1;
                        fault_adr = m_adr;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                if (!m_cyc) begin
                    state_d = ST_IDLE;
                end else if (s_ack[sel_q]) begin
                    if (!we_q) begin
                        dat_r_d = s_dat_r[sel_q*DW +: DW];
                    end
                    fault_d = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    fault_d   = 1'b1;
                    dat_r_d   = DEFAULT_DATA;
                    fault_evt = 1'b1;
                    fault_tmo = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A fault coinciding with a clear is captured rather than dropped.
    always_comb begin
        flt_valid_d = flt_valid_q;
        flt_adr_d   = flt_adr_q;
        flt_tmo_d   = flt_tmo_q;
        if (fault_evt && (!flt_valid_q || flt_clr)) begin
            flt_valid_d = 1'b1;
            flt_adr_d   = fault_adr;
            flt_tmo_d   = fault_tmo;
        end else if (flt_clr) begin
            flt_valid_d = 1'b0;
            flt_adr_d   = '0;
            flt_tmo_d   = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            adr_q       <= '0;
            dat_w_q     <= '0;
            bsel_q      <= '0;
            we_q        <= 1'b0;
            dat_r_q     <= '0;
            fault_q     <= 1'b0;
            flt_valid_q <= 1'b0;
            flt_adr_q   <= '0;
            flt_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            adr_q       <= adr_d;
            dat_w_q     <= dat_w_d;
            bsel_q      <= bsel_d;
            we_q        <= we_d;
            dat_r_q     <= dat_r_d;
            fault_q     <= fault_d;
            flt_valid_q <= flt_valid_d;
            flt_adr_q   <= flt_adr_d;
            flt_tmo_q   <= flt_tmo_d;
        end
    end

    always_comb begin
        s_stb = '0;
        if (state_q == ST_REQ) begin
            s_stb[sel_q] = 1'b1;
        end
    end

    assign m_ack     = (state_q == ST_RESP) && (!fault_q || !ERR_MODE);
    assign m_err     = (state_q == ST_RESP) && fault_q && ERR_MODE;
    assign m_dat_r   = dat_r_q;
    assign s_adr     = adr_q;
    assign s_dat_w   = dat_w_q;
    assign s_sel     = bsel_q;
    assign s_we      = we_q;
    assign flt_valid = flt_valid_q;
    assign flt_adr   = flt_adr_q;
    assign flt_tmo   = flt_tmo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_slave_fabric.sv
// Directed bench for wb_slave_fabric: two instances share all master/slave inputs,
// one closing faults with m_ack (dut_a) and one with m_err (dut_b).
module tb_wb_slave_fabric;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [N*AW-1:0] BASE = {32'h0340_0000, 32'h0340_0000, 32'h0330_0000};
    localparam logic [N*AW-1:0] MASK = {32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    localparam logic [DW-1:0]   DEF  = 32'hBADA_CCE5;

    logic            sys_clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   m_adr;
    logic [DW-1:0]   m_dat_w;
    logic [3:0]      m_sel;
    logic            m_we, m_cyc, m_stb;
    logic [N*DW-1:0] s_dat_r;
    logic [N-1:0]    s_ack;
    logic            flt_clr;

    logic [DW-1:0] a_m_dat_r, b_m_dat_r;
    logic          a_m_ack, b_m_ack, a_m_err, b_m_err;
    logic [AW-1:0] a_s_adr, b_s_adr;
    logic [DW-1:0] a_s_dat_w, b_s_dat_w;
    logic [3:0]    a_s_sel, b_s_sel;
    logic          a_s_we, b_s_we;
    logic [N-1:0]  a_s_stb, b_s_stb;
    logic          a_flt_valid, b_flt_valid, a_flt_tmo, b_flt_tmo;
    logic [AW-1:0] a_flt_adr, b_flt_adr;
    logic [1:0]    a_dbg_state, b_dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    wb_slave_fabric #(.NUM_SLAVES(N), .AW(AW), .DW(DW), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
                      .TIMEOUT(8), .DEFAULT_DATA(DEF), .ERR_MODE(1'b0)) dut_a (
        .sys_clk(sys_clk), .reset(reset), .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
        .m_we(m_we), .m_cyc(m_cyc), .m_stb(m_stb), .m_dat_r(a_m_dat_r), .m_ack(a_m_ack),
        .m_err(a_m_err), .s_adr(a_s_adr), .s_dat_w(a_s_dat_w), .s_sel(a_s_sel), .s_we(a_s_we),
        .s_stb(a_s_stb), .s_dat_r(s_dat_r), .s_ack(s_ack), .flt_clr(flt_clr),
        .flt_valid(a_flt_valid), .flt_adr(a_flt_adr), .flt_tmo(a_flt_tmo), .dbg_state(a_dbg_state));

    wb_slave_fabric #(.NUM_SLAVES(N), .AW(AW), .DW(DW), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
                      .TIMEOUT(8), .DEFAULT_DATA(DEF), .ERR_MODE(1'b1)) dut_b (
        .sys_clk(sys_clk), .reset(reset), .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
        .m_we(m_we), .m_cyc(m_cyc), .m_stb(m_stb), .m_dat_r(b_m_dat_r), .m_ack(b_m_ack),
        .m_err(b_m_err), .s_adr(b_s_adr), .s_dat_w(b_s_dat_w), .s_sel(b_s_sel), .s_we(b_s_we),
        .s_stb(b_s_stb), .s_dat_r(s_dat_r), .s_ack(s_ack), .flt_clr(flt_clr),
        .flt_valid(b_flt_valid), .flt_adr(b_flt_adr), .flt_tmo(b_flt_tmo), .dbg_state(b_dbg_state));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wb_start(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat);
        m_adr   = adr;
        m_we    = we;
        m_dat_w = dat;
        m_sel   = 4'hF;
        m_cyc   = 1'b1;
        m_stb   = 1'b1;
    endtask

    task automatic wb_end();
        m_cyc = 1'b0;
        m_stb = 1'b0;
        m_we  = 1'b0;
    endtask

    task automatic unmapped(input string tag, input logic [AW-1:0] adr);
        wb_start(adr, 1'b1, 32'h0);
        tick();
        check({tag, "_ack"}, 64'(a_m_ack), 64'd1);
        wb_end();
        tick();
    endtask

    initial begin
        reset   = 1'b1;
        flt_clr = 1'b0;
        s_ack   = '0;
        s_dat_r = {32'h5A5A_5A5A, 32'h1234_5678, 32'hAAAA_0000};
        m_adr   = '0;
        m_dat_w = '0;
        m_sel   = '0;
        wb_end();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_state", 64'(a_dbg_state), 64'd0);
        check("rst_dat_r", 64'(a_m_dat_r), 64'd0);
        check("rst_ack", 64'({a_m_ack, a_m_err, b_m_ack, b_m_err}), 64'd0);
        check("rst_stb", 64'(a_s_stb), 64'd0);
        check("rst_flt", 64'({a_flt_valid, a_flt_tmo, a_flt_adr}), 64'd0);

        // Read slave 1 (both slave 1 and 2 windows match; lowest wins), ack at T+3.
        wb_start(32'h0340_0010, 1'b0, 32'h0);
        exp_q.push_back(32'h1234_5678);
        tick();
        check("t1_stb1", 64'(a_s_stb), 64'b010);
        check("t1_adr", 64'(a_s_adr), 64'h0340_0010);
        check("t1_ack1", 64'(a_m_ack), 64'd0);
        tick();
        check("t1_stb2", 64'(a_s_stb), 64'b010);
        tick();
        check("t1_stb3", 64'(a_s_stb), 64'b010);
        s_ack = 3'b010;
        tick();
        s_ack = '0;
        check("t1_ack4", 64'(a_m_ack), 64'd1);
        check("t1_dat", 64'(a_m_dat_r), 64'(exp_q.pop_front()));
        check("t1_stb4", 64'(a_s_stb), 64'd0);
        wb_end();
        tick();
        check("t1_ack5", 64'(a_m_ack), 64'd0);

        // Slave 2 only window, zero-wait ack.
        wb_start(32'h0348_0000, 1'b0, 32'h0);
        exp_q.push_back(32'h5A5A_5A5A);
        tick();
        check("pri_stb", 64'(a_s_stb), 64'b100);
        s_ack = 3'b111;
        tick();
        s_ack = '0;
        check("pri_ack", 64'(a_m_ack), 64'd1);
        check("pri_dat", 64'(a_m_dat_r), 64'(exp_q.pop_front()));
        wb_end();
        tick();

        // Ack arrives in the expiry cycle: normal completion wins.
        wb_start(32'h0330_0004, 1'b0, 32'h0);
        exp_q.push_back(32'hAAAA_0000);
        tick();
        repeat (7) tick();
        check("t4_stb8", 64'(a_s_stb), 64'b001);
        check("t4_ack8", 64'(a_m_ack), 64'd0);
        s_ack = 3'b001;
        tick();
        s_ack = '0;
        check("t4_ack9", 64'({a_m_ack, b_m_ack, b_m_err}), 64'b110);
        check("t4_dat", 64'(a_m_dat_r), 64'(exp_q.pop_front()));
        check("t4_flt", 64'({a_flt_valid, b_flt_valid}), 64'd0);
        wb_end();
        tick();

        // Unmapped write.
        wb_start(32'h0320_0000, 1'b1, 32'hCAFE_F00D);
        tick();
        check("t2_ack", 64'(a_m_ack), 64'd1);
        check("t2_err_b", 64'({b_m_err, b_m_ack}), 64'b10);
        check("t2_stb", 64'(a_s_stb), 64'd0);
        check("t2_dat", 64'(a_m_dat_r), 64'(DEF));
        check("t2_wdat", 64'({a_s_we, a_s_dat_w}), {31'd0, 1'b1, 32'hCAFE_F00D});
        check("t2_flt", 64'({a_flt_valid, a_flt_tmo}), 64'b10);
        check("t2_flt_adr", 64'(a_flt_adr), 64'h0320_0000);
        wb_end();
        tick();
        check("t2_stb_after", 64'(a_s_stb), 64'd0);

        flt_clr = 1'b1;
        tick();
        flt_clr = 1'b0;
        check("clr", 64'({a_flt_valid, b_flt_valid}), 64'd0);

        // Slave 0 never acks: timeout fault at T+9.
        wb_start(32'h0330_0000, 1'b0, 32'h0);
        tick();
        repeat (7) tick();
        check("t3_stb8", 64'(a_s_stb), 64'b001);
        check("t3_ack8", 64'({a_m_ack, b_m_err}), 64'd0);
        tick();
        check("t3_ack_a", 64'({a_m_ack, a_m_err}), 64'b10);
        check("t3_dat_a", 64'(a_m_dat_r), 64'(DEF));
        check("t3_err_b", 64'({b_m_err, b_m_ack}), 64'b10);
        check("t3_dat_b", 64'(b_m_dat_r), 64'(DEF));
        check("t3_flt_b", 64'({b_flt_valid, b_flt_tmo}), 64'b11);
        check("t3_flt_adr", 64'(a_flt_adr), 64'h0330_0000);
        check("t3_stb9", 64'(a_s_stb), 64'd0);
        wb_end();
        tick();

        // Abort by dropping m_cyc in REQ, then a fresh request.
        wb_start(32'h0340_0020, 1'b0, 32'h0);
        tick();
        tick();
        wb_end();
        tick();
        check("t5_stb3", 64'(a_s_stb), 64'd0);
        check("t5_ack3", 64'(a_m_ack), 64'd0);
        check("t5_state", 64'(a_dbg_state), 64'd0);
        tick();
        check("t5_ack4", 64'(a_m_ack), 64'd0);
        wb_start(32'h0348_0000, 1'b0, 32'h0);
        exp_q.push_back(32'h5A5A_5A5A);
        tick();
        check("t5_stb5", 64'(a_s_stb), 64'b100);
        s_ack = 3'b100;
        tick();
        s_ack = '0;
        check("t5_ack6", 64'(a_m_ack), 64'd1);
        check("t5_dat", 64'(a_m_dat_r), 64'(exp_q.pop_front()));
        wb_end();
        tick();

        // Back-to-back faults, then a clear coinciding with a third fault.
        flt_clr = 1'b1;
        tick();
        flt_clr = 1'b0;
        unmapped("t6_a", 32'h0310_0000);
        unmapped("t6_b", 32'h0320_0004);
        check("t6_keep", 64'(a_flt_adr), 64'h0310_0000);
        wb_start(32'h0360_0008, 1'b0, 32'h0);
        flt_clr = 1'b1;
        #1;
        check("t6_pre", 64'(a_flt_adr), 64'h0310_0000);
        tick();
        flt_clr = 1'b0;
        check("t6_new", 64'(a_flt_adr), 64'h0360_0008);
        check("t6_valid", 64'({a_flt_valid, a_flt_tmo}), 64'b10);
        wb_end();
        tick();

        // Reset while a request is outstanding.
        wb_start(32'h0340_0000, 1'b0, 32'h0);
        tick();
        check("rm_stb", 64'(a_s_stb), 64'b010);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wb_end();
        check("rm_stb0", 64'(a_s_stb), 64'd0);
        check("rm_ack", 64'({a_m_ack, b_m_err}), 64'd0);
        check("rm_state", 64'(a_dbg_state), 64'd0);
        tick();
        check("rm_ack2", 64'({a_m_ack, b_m_err}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
